exp_sum_accum: RTL and testbench



---
 rtl/exp_sum_accum.sv | 195 +++++++++++++++++++
 tb/tb_exp_sum_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exp_sum_accum.sv
// Accumulates a stream of bf16 exp() values per vector into a saturating fixed-point sum,
// then normalises it back to bf16. Optional ROUND_NEAREST_EN selects round-to-nearest-even packing.
module exp_sum_accum #(
    parameter int ACC_W  = 32,
    parameter int FRAC_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        NORM   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int K_W = $clog2(ACC_W);
    localparam logic signed [10:0] SH_OFFSET = 11'(FRAC_W - 7 - 127);
    localparam int OVF_EXP = 127 + ACC_W - FRAC_W;
    localparam logic [9:0] EXP_BASE = 10'(127 + ACC_W - 1 - FRAC_W);

    state_t state, state_nxt;

    logic             armed;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [K_W-1:0]   k;

    logic                    beat_sign;
    logic [7:0]              beat_exp;
    logic [7:0]              beat_mant;
    logic signed [10:0]      sh;
    logic [10:0]             sh_mag;
    logic [ACC_W-1:0]        beat_val;
    logic                    beat_ovf;
    logic                    beat_fire;
    logic [ACC_W:0]          sum_ext;

    logic        acc_zero;
    logic        norm_done;
    logic [9:0]  pack_exp;
    logic [6:0]  pack_mant;
    logic [15:0] pack_sum;

    // Convert one bf16 beat to accumulator fixed point; negative, zero and denormal inputs vanish.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        beat_val  = '0;
        beat_ovf  = 1'b0;
        beat_sign = in_data[15];
        beat_exp  = in_data[14:7];
        beat_mant = {1'b1, in_data[6:0]};
        sh        = $signed({3'b000, beat_exp}) + SH_OFFSET;
        sh_mag    = sh[10] ? -sh : sh;
        if (!beat_sign && beat_exp != 8'd0) begin
            if (beat_exp == 8'hFF || int'(beat_exp) >= OVF_EXP) begin
                beat_ovf = 1'b1;
            end else if (sh[10]) begin
                beat_val = ACC_W'(beat_mant >> sh_mag);
            end else begin
                beat_val = {{(ACC_W-8){1'b0}}, beat_mant} << sh_mag;
            end
        end
    end

    assign beat_fire = in_valid && in_ready;
    assign sum_ext   = {1'b0, acc} + {1'b0, beat_val};

    assign acc_zero  = (acc == '0);
    assign norm_done = acc_zero || ovf || acc[ACC_W-1];

`ifdef ROUND_NEAREST_EN
    logic       guard_bit;
    logic       sticky_bit;
    logic       round_up;
    logic [8:0] mant_rnd;

    // Round-to-nearest-even on the 8-bit significand; a carry out bumps the exponent.
    always_comb begin
        guard_bit  = acc[ACC_W-9];
        sticky_bit = |acc[ACC_W-10:0];
        round_up   = guard_bit && (sticky_bit || acc[ACC_W-8]);
        mant_rnd   = {2'b01, acc[ACC_W-2 -: 7]} + 9'(round_up);
        pack_mant  = mant_rnd[6:0];
        pack_exp   = EXP_BASE - 10'(k) + 10'(mant_rnd[8]);
    end
`else
    always_comb begin
        pack_mant = acc[ACC_W-2 -: 7];
        pack_exp  = EXP_BASE - 10'(k);
    end
`endif

    always_comb begin
        pack_sum = {1'b0, pack_exp[7:0], pack_mant};
        if (ovf) begin
            pack_sum = 16'h7F80;
        end else if (acc_zero) begin
            pack_sum = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = armed;
                if (beat_fire && in_last) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (norm_done) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Datapath: accumulate in ACCUM, normalise one bit per cycle in NORM, clear on result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            k         <= '0;
            out_sum   <= 16'h0000;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            armed <= 1'b1;
            case (state)
                ACCUM: begin
                    if (beat_fire) begin
                        acc <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                        ovf <= ovf || beat_ovf || sum_ext[ACC_W];
                        if (count != '1) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        out_sum   <= pack_sum;
                        out_count <= count;
                        out_ovf   <= ovf;
                    end else begin
                        acc <= acc << 1;
                        k   <= k + K_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        k     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_sum_accum.sv
// Directed bench for exp_sum_accum: hand-computed bf16 sums, latency, stall and mid-NORM reset.
module tb_exp_sum_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    exp_sum_accum #(.ACC_W(32), .FRAC_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("send_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the last beat's accepting edge; lat counts cycles until out_valid.
    task automatic wait_out(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_valid_after"}, out_valid, 0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] sum,
                                input logic [7:0] cnt, input logic ovf);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, sum);
        check({tag, "_count"}, out_count, cnt);
        check({tag, "_ovf"}, out_ovf, ovf);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 16'h0000);
        check("rst_count", out_count, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", in_ready, 1);

        // Single beat 1.0: sum 0x10000, 15 shifts
        send(16'h3F80, 1'b1);
        wait_out(lat);
        check_result("one", 16'h3F80, 8'd1, 1'b0);
        check("one_latency", lat, 16);
        accept("one");

        // 1+2+3+4 = 10.0
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4040, 1'b0);
        send(16'h4080, 1'b1);
        wait_out(lat);
        check_result("ten", 16'h4120, 8'd4, 1'b0);
        check("ten_latency", lat, 13);
        accept("ten");

        // 65536.0 exceeds integer range
        send(16'h4780, 1'b1);
        wait_out(lat);
        check_result("big", 16'h7F80, 8'd1, 1'b1);
        check("big_latency", lat, 1);
        accept("big");

        // Infinity input then a normal beat
        send(16'h7F80, 1'b0);
        send(16'h3F80, 1'b1);
        wait_out(lat);
        check_result("inf", 16'h7F80, 8'd2, 1'b1);
        accept("inf");

        // Zero and negative contribute nothing
        send(16'h0000, 1'b0);
        send(16'hBF80, 1'b1);
        wait_out(lat);
        check_result("zero", 16'h0000, 8'd2, 1'b0);
        check("zero_latency", lat, 1);
        accept("zero");

        // 1.0 + 0.005859375: guard and sticky set
        send(16'h3F80, 1'b0);
        send(16'h3BC0, 1'b1);
        wait_out(lat);
`ifdef ROUND_NEAREST_EN
        check_result("rnd", 16'h3F81, 8'd2, 1'b0);
`else
        check_result("rnd", 16'h3F80, 8'd2, 1'b0);
`endif
        accept("rnd");

        // Output stall with a pending input beat
        send(16'h3F80, 1'b1);
        wait_out(lat);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_sum", out_sum, 16'h3F80);
            check("stall_count", out_count, 1);
            check("stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h4000, 1'b1);
        wait_out(lat);
        check_result("held", 16'h4000, 8'd1, 1'b0);
        accept("held");

        // Reset pulsed while in NORM
        send(16'h3F80, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("nrst_valid", out_valid, 0);
        check("nrst_sum", out_sum, 16'h0000);
        check("nrst_count", out_count, 0);
        check("nrst_ovf", out_ovf, 0);
        check("nrst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("nrst_ready_after", in_ready, 1);
        send(16'h4000, 1'b1);
        wait_out(lat);
        check_result("post", 16'h4000, 8'd1, 1'b0);
        check("post_latency", lat, 15);
        accept("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
